// File: rtl/instruction_decode_buffer_if.sv
// Fetch-side and issue-side signals of the instruction decode buffer.
// master = manager/consumer environment, slave = the buffer itself.
interface instruction_decode_buffer_if;
    logic        readyFlag;
    logic [31:0] instructionInput;
    logic        fetchHold;
    logic        parallelFlag;
    logic [7:0]  parallelAddress;
    logic        outValid;
    logic        outReady;
    logic [3:0]  opcode;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [15:0] imm;
    logic        overflowFlag;
    logic        halted;

    modport master (
        output readyFlag, instructionInput, outReady,
        input  fetchHold, parallelFlag, parallelAddress, outValid,
               opcode, rd, rs1, rs2, imm, overflowFlag, halted
    );

    modport slave (
        input  readyFlag, instructionInput, outReady,
        output fetchHold, parallelFlag, parallelAddress, outValid,
               opcode, rd, rs1, rs2, imm, overflowFlag, halted
    );
endinterface

// File: rtl/instruction_decode_buffer.sv
// Small FIFO between the instruction manager and execute: decodes the head word,
// redirects fetch on a jump and freezes issue on a halt.
module instruction_decode_buffer #(
    parameter int       DEPTH   = 4,
    parameter bit [3:0] JUMP_OP = 4'h8,
    parameter bit [3:0] HALT_OP = 4'hF
) (
    input  logic                          clk,
    input  logic                          rst,
    instruction_decode_buffer_if.slave    bus
);
    localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
    localparam logic [PW:0]   CNT_HOLD = (PW+1)'(DEPTH - 1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_REDIRECT = 2'd1,
        S_HALTED   = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0]  opcode;
        logic [3:0]  rd;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [15:0] imm;
    } instr_t;

    state_t        state, state_nxt;
    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count, count_nxt;

    logic          fetch_hold_q;
    logic          overflow_q;
    logic [7:0]    paddr_q;

    instr_t        head;
    logic          empty, full, run;
    logic          pop, pop_jump, pop_halt, push, drop;
    logic          out_valid, parallel_flag, halted_o;

    // ---------------------------------------------------------------- datapath control
    always_comb begin
        head     = instr_t'(mem[rd_ptr]);
        empty    = (count == '0);
        full     = (count == CNT_FULL);
        run      = (state == S_RUN);
        pop      = out_valid && bus.outReady;
        pop_jump = pop && (head.opcode == JUMP_OP);
        pop_halt = pop && (head.opcode == HALT_OP);
        // A jump flushes the queue, so a word arriving alongside it is lost too.
        push     = run && bus.readyFlag && (!full || pop) && !pop_jump;
        drop     = run && bus.readyFlag && full && !pop;
    end

    always_comb begin
        count_nxt = count;
        if (pop_jump)
            count_nxt = '0;
        else if (push && !pop)
            count_nxt = count + CNT_ONE;
        else if (pop && !push)
            count_nxt = count - CNT_ONE;
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_RUN;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        out_valid     = 1'b0;
        parallel_flag = 1'b0;
        halted_o      = 1'b0;
        case (state)
            S_RUN: begin
                out_valid = !empty;
                if (pop_jump)
                    state_nxt = S_REDIRECT;
                else if (pop_halt)
                    state_nxt = S_HALTED;
            end
            S_REDIRECT: begin
                parallel_flag = 1'b1;
                state_nxt     = S_RUN;
            end
            S_HALTED: begin
                halted_o = 1'b1;
            end
            default: state_nxt = S_RUN;
        endcase
    end

    // ---------------------------------------------------------------- storage
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= bus.instructionInput;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            fetch_hold_q <= 1'b0;
            overflow_q   <= 1'b0;
            paddr_q      <= '0;
        end else begin
            count        <= count_nxt;
            // Hold looks at the post-update count so the manager sees it one cycle later;
            // the final slot covers the word already in flight.
            fetch_hold_q <= (count_nxt >= CNT_HOLD);
            if (drop)
                overflow_q <= 1'b1;
            if (pop_jump) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                paddr_q <= head.imm[7:0];
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + PTR_ONE;
                if (pop)
                    rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // ---------------------------------------------------------------- outputs
    assign bus.fetchHold       = fetch_hold_q;
    assign bus.parallelFlag    = parallel_flag;
    assign bus.parallelAddress = paddr_q;
    assign bus.outValid        = out_valid;
    assign bus.overflowFlag    = overflow_q;
    assign bus.halted          = halted_o;
    assign bus.opcode          = empty ? 4'h0  : head.opcode;
    assign bus.rd              = empty ? 4'h0  : head.rd;
    assign bus.rs1             = empty ? 4'h0  : head.rs1;
    assign bus.rs2             = empty ? 4'h0  : head.rs2;
    assign bus.imm             = empty ? 16'h0 : head.imm;

endmodule

// File: tb/tb_instruction_decode_buffer.sv
// Randomized scoreboard bench for instruction_decode_buffer: a queue-based reference
// model produces per-cycle expectations and popped words; a negedge monitor compares.
module tb_instruction_decode_buffer;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instruction_decode_buffer_if bus();

    instruction_decode_buffer #(.DEPTH(DEPTH), .JUMP_OP(4'h8), .HALT_OP(4'hF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic        valid;
        logic        pflag;
        logic [7:0]  paddr;
        logic        hold;
        logic        ovf;
        logic        halted;
        logic [31:0] head;
    } stat_t;

    typedef enum int {M_RUN, M_REDIR, M_HALT} mst_t;

    int          checks = 0;
    int          errors = 0;

    stat_t       stat_q[$];
    logic [31:0] exp_q[$];

    // reference model state
    logic [31:0] mq[$];
    mst_t        ms;
    logic        m_ovf, m_hold;
    logic [7:0]  m_paddr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        stat_q.delete();
        exp_q.delete();
        ms      = M_RUN;
        m_ovf   = 1'b0;
        m_hold  = 1'b0;
        m_paddr = 8'h0;
    endtask

    // One cycle of the reference: record what the DUT must show now, then advance.
    task automatic model_step(input bit rf, input logic [31:0] w, input bit ordy);
        stat_t       s;
        logic [31:0] top;
        bit          popped;
        s.valid  = (ms == M_RUN) && (mq.size() != 0);
        s.pflag  = (ms == M_REDIR);
        s.paddr  = m_paddr;
        s.hold   = m_hold;
        s.ovf    = m_ovf;
        s.halted = (ms == M_HALT);
        s.head   = (mq.size() != 0) ? mq[0] : 32'h0;
        stat_q.push_back(s);
        top    = 32'h0;
        popped = 1'b0;
        case (ms)
            M_REDIR: ms = M_RUN;
            M_HALT:  ;
            default: begin
                if (s.valid && ordy) begin
                    top = mq.pop_front();
                    exp_q.push_back(top);
                    popped = 1'b1;
                end
                if (popped && top[31:28] == 4'h8) begin
                    mq.delete();
                    m_paddr = top[7:0];
                    ms      = M_REDIR;
                end else begin
                    if (popped && top[31:28] == 4'hF)
                        ms = M_HALT;
                    if (rf) begin
                        if (mq.size() < DEPTH) mq.push_back(w);
                        else                   m_ovf = 1'b1;
                    end
                end
            end
        endcase
        m_hold = (mq.size() >= DEPTH - 1);
    endtask

    task automatic cyc(input bit rf, input logic [31:0] w, input bit ordy);
        @(posedge clk);
        #1;
        bus.readyFlag        = rf;
        bus.instructionInput = w;
        bus.outReady         = ordy;
        model_step(rf, w, ordy);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_outValid"},  32'(bus.outValid), 32'h0);
        chk({tag, "_halted"},    32'(bus.halted), 32'h0);
        chk({tag, "_fetchHold"}, 32'(bus.fetchHold), 32'h0);
        chk({tag, "_pflag"},     32'(bus.parallelFlag), 32'h0);
        chk({tag, "_paddr"},     32'(bus.parallelAddress), 32'h0);
        chk({tag, "_ovf"},       32'(bus.overflowFlag), 32'h0);
        chk({tag, "_fields"},    {bus.opcode, bus.rd, bus.rs1, bus.rs2, bus.imm}, 32'h0);
    endtask

    // Reset lands mid-cycle, well away from either clock edge.
    task automatic async_reset(input string tag);
        @(negedge clk);
        #2;
        chk({tag, "_exp_drained"}, exp_q.size(), 0);
        rst = 1'b1;
        #1;
        chk_zero(tag);
        bus.readyFlag = 1'b0;
        bus.outReady  = 1'b0;
        model_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        stat_t s;
        if (stat_q.size() != 0) begin
            s = stat_q.pop_front();
            chk("outValid",     32'(bus.outValid), 32'(s.valid));
            chk("parallelFlag", 32'(bus.parallelFlag), 32'(s.pflag));
            chk("parallelAddr", 32'(bus.parallelAddress), 32'(s.paddr));
            chk("fetchHold",    32'(bus.fetchHold), 32'(s.hold));
            chk("overflowFlag", 32'(bus.overflowFlag), 32'(s.ovf));
            chk("halted",       32'(bus.halted), 32'(s.halted));
            chk("fields", {bus.opcode, bus.rd, bus.rs1, bus.rs2, bus.imm}, s.head);
            if (bus.outValid && bus.outReady) begin
                if (exp_q.size() == 0)
                    chk("unexpected_pop", 32'h1, 32'h0);
                else
                    chk("popped_word", {bus.opcode, bus.rd, bus.rs1, bus.rs2, bus.imm},
                        exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [31:0] w;
        logic [3:0]  op;
        bit          rf, ordy;
        int          k;

        rst                  = 1'b1;
        bus.readyFlag        = 1'b0;
        bus.instructionInput = 32'h0;
        bus.outReady         = 1'b0;
        model_reset();
        #3;
        chk_zero("por");
        @(negedge clk);
        #2;
        rst = 1'b0;

        // idle after reset with consumer ready
        repeat (3) cyc(1'b0, 32'h0, 1'b1);

        // single word, fields decoded one cycle later
        cyc(1'b1, 32'h1234ABCD, 1'b0);
        repeat (2) cyc(1'b0, 32'h0, 1'b0);
        async_reset("r1");

        // fill past capacity, then drain in order
        for (int i = 1; i <= 5; i++) cyc(1'b1, {4'(i), 4'h1, 4'h2, 4'h3, 16'(i * 16'h1111)}, 1'b0);
        cyc(1'b0, 32'h0, 1'b0);
        repeat (6) cyc(1'b0, 32'h0, 1'b1);
        async_reset("r2");

        // jump with a trailing word that must vanish
        cyc(1'b1, 32'h80000042, 1'b1);
        cyc(1'b1, 32'h11110000, 1'b1);
        repeat (4) cyc(1'b0, 32'h0, 1'b1);
        async_reset("r3");

        // halt, then later words ignored; reset clears it
        cyc(1'b1, 32'hF0000000, 1'b1);
        cyc(1'b1, 32'h22220000, 1'b1);
        repeat (3) cyc(1'b1, 32'h33330000, 1'b1);
        async_reset("r4");

        // streaming push+pop, pointers wrap
        for (int i = 0; i < 10; i++) cyc(1'b1, {4'h2, 4'(i), 8'hA5, 16'(i + 100)}, 1'b1);
        repeat (2) cyc(1'b0, 32'h0, 1'b1);

        // randomized rounds; odd rounds obey fetchHold, even rounds ignore it
        for (int r = 0; r < 16; r++) begin
            async_reset("rnd");
            for (int c = 0; c < 60; c++) begin
                k = int'($urandom_range(0, 39));
                if (k < 3)       op = 4'h8;
                else if (k == 3) op = 4'hF;
                else begin
                    op = 4'($urandom_range(0, 14));
                    if (op == 4'h8) op = 4'h1;
                end
                w    = {op, 28'($urandom())};
                rf   = ($urandom_range(0, 3) != 0) && ((r % 2 == 0) || !m_hold);
                ordy = (r % 4 < 2) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 3) == 0);
                cyc(rf, w, ordy);
            end
            repeat (2) cyc(1'b0, 32'h0, 1'b1);
        end

        @(negedge clk);
        #2;
        chk("final_exp_drained", exp_q.size(), 0);
        chk("final_stat_drained", stat_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/instruction_decode_buffer.md
Name: instruction_decode_buffer

Overview:
- Downstream neighbour of instructionManager: captures each 32-bit word it presents on readyFlag into a small FIFO.
- Splits the head word into decoded fields and hands them to the execute/pixel-decrypt stage over a valid/ready handshake.
- Drives the manager's parallelFlag/parallelAddress to redirect fetch on a jump, and throttles fetch when nearly full.

Parameters:
- DEPTH, 4, FIFO entries (power of two, >=2).
- JUMP_OP, 4'h8, opcode that redirects fetch.
- HALT_OP, 4'hF, opcode that stops issue until reset.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- readyFlag  in  1  manager strobe; instructionInput valid this cycle.
- instructionInput  in  32  fetched instruction word.
- fetchHold  out  1  high when count >= DEPTH-1; manager must pause fetch.
- parallelFlag  out  1  one-cycle fetch redirect request.
- parallelAddress  out  8  redirect target, valid when parallelFlag=1.
- outValid  out  1  decoded head instruction available.
- outReady  in  1  consumer accepts head this cycle.
- opcode  out  4  head[31:28].
- rd  out  4  head[27:24].
- rs1  out  4  head[23:20].
- rs2  out  4  head[19:16].
- imm  out  16  head[15:0].
- overflowFlag  out  1  sticky; a word arrived while full.
- halted  out  1  HALTED state indicator.

Behaviour:
- Reset, asynchronous, any time including mid-redirect:
  - rd/wr pointers=0, count=0, state=RUN.
  - All outputs 0: fetchHold, parallelFlag, parallelAddress, outValid, overflowFlag, halted, field outputs.
- States: RUN, REDIRECT, HALTED.
- Push, RUN only: readyFlag=1 and (count<DEPTH or pop this cycle) -> write instructionInput at wr pointer, wr pointer +1 mod DEPTH.
  - readyFlag=1 while full with no pop -> word dropped, overflowFlag set until rst.
- Output:
  - outValid = (count!=0) && state==RUN.
  - Field outputs are combinational slices of the head entry; 0 when count==0.
  - No bypass: a word pushed into an empty FIFO gives outValid on the next cycle (1-cycle latency).
- Pop: outValid && outReady -> rd pointer +1 mod DEPTH.
  - Simultaneous push+pop leaves count unchanged; wrap-around of both pointers is legal.
- Jump: popping a head with opcode==JUMP_OP:
  - Clear the FIFO (pointers=0, count=0) at that edge; any concurrent push is discarded.
  - state -> REDIRECT.
  - REDIRECT lasts exactly one cycle: parallelFlag=1, parallelAddress=popped imm[7:0], outValid=0, readyFlag ignored.
  - Next cycle -> RUN, parallelFlag=0; parallelAddress holds its last value.
- Halt: popping a head with opcode==HALT_OP:
  - state -> HALTED, halted=1.
  - outValid=0; pushes ignored; FIFO contents frozen.
  - Only rst leaves HALTED.
- Non-jump, non-halt opcodes pass through with no side effects.
- fetchHold is registered from post-update count: asserts the cycle after count reaches DEPTH-1.
  - The manager may still deliver one word after fetchHold rises; the last slot absorbs it.
- Priority in a cycle: rst > HALTED > REDIRECT > pop/push.

Test Plan:
- Reset then idle, outReady=1 -> all outputs 0, halted=0.
- readyFlag with 0x1234ABCD, outReady=0 -> next cycle outValid=1, opcode=1, rd=2, rs1=3, rs2=4, imm=0xABCD.
- Five consecutive pushes, outReady=0, DEPTH=4 -> fetchHold=1 after the 3rd push; 5th word dropped, overflowFlag=1; then pop four with outReady=1 and get words 1-4 in order.
- Push 0x80000042 then 0x11110000, popping continuously -> one cycle with parallelFlag=1, parallelAddress=0x42; second word never appears on outValid; FIFO empty.
- Push 0xF0000000 then 0x22220000 -> halted=1, outValid stays 0, later readyFlag ignored; assert rst mid-cycle -> halted=0, count=0 immediately.
- Interleaved push+pop every cycle for 10 words -> pointers wrap, count constant at 1, output order matches input order.
